// File: rtl/instruc_fetch_if.sv
// Memory read bus between the instruction fetch unit and instruction memory.
// Uses a req/ack handshake: mem_rd is held until mem_ack returns the word.
interface instruc_fetch_if #(
    parameter int ADDR_W = 9
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/instruc_fetch.sv
// Instruction fetch unit: PC, one memory read per start, IR load strobe.
// Optional REQ timeout with fetch_err pulse under FETCH_TIMEOUT_EN.
module instruc_fetch #(
    parameter int                ADDR_W      = 9,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    instruc_fetch_if.master   mem,
    output logic [15:0]       ir_data,
    output logic              load_ir,
    output logic              fetch_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOAD
    } state_t;

    state_t state;
    logic   rd_q;
    logic   err_q;
    logic   tmo_hit;

    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = pc;
    assign fetch_err    = err_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;

    // Counts REQ cycles that ended without an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == REQ && !mem.mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign tmo_hit = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir_data    <= '0;
            rd_q       <= 1'b0;
            load_ir    <= 1'b0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            load_ir    <= 1'b0;
            fetch_done <= 1'b0;
            err_q      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc <= pc_in;
                    end else if (start) begin
                        state <= REQ;
                        rd_q  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        ir_data    <= mem.mem_rdata;
                        pc         <= pc + 1'b1;
                        state      <= LOAD;
                        rd_q       <= 1'b0;
                        load_ir    <= 1'b1;
                        fetch_done <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        busy  <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruc_fetch.sv
// Bench for instruc_fetch: directed literal cases, then random traffic
// compared every cycle against a transaction-level model.
module tb_instruc_fetch;

    localparam int ADDR_W      = 9;
    localparam int TIMEOUT_CYC = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              pc_load = 1'b0;
    logic [ADDR_W-1:0] pc_in = '0;
    logic [15:0]       ir_data;
    logic              load_ir;
    logic              fetch_done;
    logic              busy;
    logic [ADDR_W-1:0] pc;
    logic              fetch_err;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    instruc_fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

    instruc_fetch #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    ('0),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem        (mem_bus),
        .ir_data    (ir_data),
        .load_ir    (load_ir),
        .fetch_done (fetch_done),
        .busy       (busy),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: phase 0=waiting for a request, 1=read outstanding, 2=word delivered.
    int              m_phase;
    int              m_waits;
    bit              m_err;
    logic [ADDR_W-1:0] m_pc;
    logic [15:0]     m_ir;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_waits <= 0;
            m_err   <= 1'b0;
            m_pc    <= '0;
            m_ir    <= 16'h0000;
        end else begin
            m_err <= 1'b0;
            if (m_phase == 0) begin
                if (pc_load) m_pc <= pc_in;
                else if (start) begin
                    m_phase <= 1;
                    m_waits <= 0;
                end
            end else if (m_phase == 1) begin
                if (mem_bus.mem_ack) begin
                    m_ir    <= mem_bus.mem_rdata;
                    m_pc    <= ADDR_W'((int'(m_pc) + 1) % (1 << ADDR_W));
                    m_phase <= 2;
                end else begin
                    m_waits <= m_waits + 1;
`ifdef FETCH_TIMEOUT_EN
                    if (m_waits + 1 == TIMEOUT_CYC) begin
                        m_phase <= 0;
                        m_err   <= 1'b1;
                    end
`endif
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && cmp_en) begin
            chk("cyc_mem_rd", 32'(mem_bus.mem_rd), 32'(m_phase == 1));
            chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
            chk("cyc_load_ir", 32'(load_ir), 32'(m_phase == 2));
            chk("cyc_fetch_done", 32'(fetch_done), 32'(m_phase == 2));
            chk("cyc_pc", 32'(pc), 32'(m_pc));
            chk("cyc_mem_addr", 32'(mem_bus.mem_addr), 32'(m_pc));
            chk("cyc_ir_data", 32'(ir_data), 32'(m_ir));
            chk("cyc_fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_rd", 32'(mem_bus.mem_rd), 32'h0);
        chk("rst_ir", 32'(ir_data), 32'h0);
        chk("rst_load_ir", 32'(load_ir), 32'h0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        step();

        // Zero-wait fetch
        start = 1'b1;
        step();
        start = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'hD105;
        chk("zw_mem_rd", 32'(mem_bus.mem_rd), 32'h1);
        chk("zw_addr", 32'(mem_bus.mem_addr), 32'h0);
        step();
        mem_bus.mem_ack = 1'b0;
        chk("zw_load_ir", 32'(load_ir), 32'h1);
        chk("zw_done", 32'(fetch_done), 32'h1);
        chk("zw_ir", 32'(ir_data), 32'hD105);
        chk("zw_pc", 32'(pc), 32'h1);
        step();
        chk("zw_load_ir_off", 32'(load_ir), 32'h0);

        // PC write, wait states, wrap, pc_load while busy
        pc_load = 1'b1;
        pc_in   = 9'h1FF;
        step();
        pc_load = 1'b0;
        chk("wr_pc", 32'(pc), 32'h1FF);
        start = 1'b1;
        step();
        start   = 1'b0;
        pc_load = 1'b1;
        pc_in   = 9'h055;
        for (int i = 0; i < 4; i++) begin
            chk("ws_mem_rd", 32'(mem_bus.mem_rd), 32'h1);
            mem_bus.mem_ack   = (i == 3);
            mem_bus.mem_rdata = 16'h1234;
            step();
        end
        mem_bus.mem_ack = 1'b0;
        chk("ws_mem_rd_off", 32'(mem_bus.mem_rd), 32'h0);
        chk("ws_load_ir", 32'(load_ir), 32'h1);
        chk("ws_wrap_pc", 32'(pc), 32'h0);
        step();
        pc_load = 1'b0;
        chk("busy_pcload_ign", 32'(pc), 32'h0);

        // pc_load beats start
        pc_load = 1'b1;
        start   = 1'b1;
        pc_in   = 9'h020;
        step();
        pc_load = 1'b0;
        chk("prio_pc", 32'(pc), 32'h020);
        chk("prio_idle", 32'(busy), 32'h0);
        step();
        chk("prio_rd", 32'(mem_bus.mem_rd), 32'h1);
        chk("prio_addr", 32'(mem_bus.mem_addr), 32'h020);
        start = 1'b0;
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        step();

        // Back-to-back with start held
        start = 1'b1;
        step();
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'hA1B2;
        step();
        chk("b2b_ld1", 32'(load_ir), 32'h1);
        chk("b2b_ir1", 32'(ir_data), 32'hA1B2);
        mem_bus.mem_ack = 1'b0;
        step();
        chk("b2b_gap_ld", 32'(load_ir), 32'h0);
        chk("b2b_gap_busy", 32'(busy), 32'h0);
        step();
        chk("b2b_rd2", 32'(mem_bus.mem_rd), 32'h1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 16'h6043;
        step();
        chk("b2b_ld2", 32'(load_ir), 32'h1);
        chk("b2b_ir2", 32'(ir_data), 32'h6043);
        chk("b2b_pc", 32'(pc), 32'h023);
        start = 1'b0;
        mem_bus.mem_ack = 1'b0;
        step();

`ifdef FETCH_TIMEOUT_EN
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            chk("tmo_rd", 32'(mem_bus.mem_rd), 32'h1);
            step();
        end
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_busy", 32'(busy), 32'h0);
        chk("tmo_no_ld", 32'(load_ir), 32'h0);
        chk("tmo_pc", 32'(pc), 32'h023);
        step();
        chk("tmo_err_off", 32'(fetch_err), 32'h0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            start             = ($urandom_range(0, 2) == 0);
            pc_load           = ($urandom_range(0, 7) == 0);
            pc_in             = ADDR_W'($urandom);
            mem_bus.mem_ack   = ($urandom_range(0, 3) == 0);
            mem_bus.mem_rdata = 16'($urandom);
            step();
        end

        // Drain, then async reset in the middle of a request
        start   = 1'b0;
        pc_load = 1'b0;
        mem_bus.mem_ack = 1'b1;
        repeat (3) step();
        mem_bus.mem_ack = 1'b0;
        pc_load = 1'b1;
        pc_in   = 9'h005;
        step();
        pc_load = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("ar_pre_rd", 32'(mem_bus.mem_rd), 32'h1);
        chk("ar_pre_pc", 32'(pc), 32'h005);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_mem_rd", 32'(mem_bus.mem_rd), 32'h0);
        chk("ar_pc", 32'(pc), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_ir", 32'(ir_data), 32'h0);
        #3;
        reset_n = 1'b1;
        repeat (2) step();
        chk("ar_post_pc", 32'(pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
